mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares the single `sram` port between the instruction-fetch path (`program_counter`/`inst_memory`) and the load/store data path. Each requester uses a req/ack handshake. The block grants one requester at a time using round-robin order and drives `cs`/`oe`/`we`/`addr`/`din` for a fixed number of cycles. It then captures `dout` into the granted requester's read-data register and pulses that requester's ack.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one SRAM port between instruction fetch and load/store
//   fetch side : if_req_i, if_addr_i -> if_rdata_o, if_ack_o
//   data side  : d_req_i, d_we_i, d_addr_i, d_wdata_i -> d_rdata_o, d_ack_o
//   sram side  : mem_cs_o, mem_oe_o, mem_we_o, mem_addr_o, mem_din_o <- mem_dout_i
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        mem_cs_o,
  output logic        mem_oe_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_grant_q, grant_q, grant_d;
  logic        if_ack_q, d_ack_q, cs_q, oe_q, we_q;
  logic [31:0] if_rdata_q, d_rdata_q, addr_q, din_q;
  // grant encoding: 0 = fetch, 1 = data; on contention the port not served last wins
  assign grant_d = (if_req_i & d_req_i) ? ~last_grant_q : d_req_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      cs_q         <= 1'b0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (if_req_i | d_req_i) begin
          state_q      <= ACCESS;
          cnt_q        <= LAT_M1;
          grant_q      <= grant_d;
          last_grant_q <= grant_d;
          cs_q         <= 1'b1;
          we_q         <= grant_d & d_we_i;
          oe_q         <= ~(grant_d & d_we_i);
          addr_q       <= grant_d ? d_addr_i : if_addr_i;
          din_q        <= grant_d ? d_wdata_i : '0;
        end
        ACCESS: if (cnt_q == 4'd0) begin
          // oe_q doubles as the latched "this is a read" flag
          state_q <= DONE;
          if (oe_q & grant_q) d_rdata_q <= mem_dout_i;
          if (oe_q & ~grant_q) if_rdata_q <= mem_dout_i;
          if_ack_q <= ~grant_q;
          d_ack_q  <= grant_q;
          cs_q     <= 1'b0;
          oe_q     <= 1'b0;
          we_q     <= 1'b0;
          addr_q   <= '0;
          din_q    <= '0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        DONE: begin
          state_q  <= IDLE;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign if_ack_o   = if_ack_q;
  assign d_ack_o    = d_ack_q;
  assign mem_cs_o   = cs_q;
  assign mem_oe_o   = oe_q;
  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_din_o  = din_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (latency 1 and 3) checked against a transaction-timeline model
module tb_mem_port_arbiter;
  localparam int LAT [2] = '{1, 3};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic        if_req [2], d_req [2], d_we [2];
  logic [31:0] if_addr [2], d_addr [2], d_wdata [2], mem_dout [2];
  logic [31:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_din [2];
  logic        if_ack [2], d_ack [2], mem_cs [2], mem_oe [2], mem_we [2];
  mem_port_arbiter #(.MEM_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_rdata_o(if_rdata[0]), .if_ack_o(if_ack[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]),
    .d_rdata_o(d_rdata[0]), .d_ack_o(d_ack[0]),
    .mem_cs_o(mem_cs[0]), .mem_oe_o(mem_oe[0]), .mem_we_o(mem_we[0]),
    .mem_addr_o(mem_addr[0]), .mem_din_o(mem_din[0]), .mem_dout_i(mem_dout[0])
  );
  mem_port_arbiter #(.MEM_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_rdata_o(if_rdata[1]), .if_ack_o(if_ack[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]),
    .d_rdata_o(d_rdata[1]), .d_ack_o(d_ack[1]),
    .mem_cs_o(mem_cs[1]), .mem_oe_o(mem_oe[1]), .mem_we_o(mem_we[1]),
    .mem_addr_o(mem_addr[1]), .mem_din_o(mem_din[1]), .mem_dout_i(mem_dout[1])
  );
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk1(input string nm, input int i, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL u%0d.%s actual=%b required=%b @%0t", i, nm, a, e, $time);
    end
  endtask
  task automatic chk32(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL u%0d.%s actual=%h required=%h @%0t", i, nm, a, e, $time);
    end
  endtask
  task automatic chki(input string nm, input int i, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL u%0d.%s actual=%0d required=%0d @%0t", i, nm, a, e, $time);
    end
  endtask
  // Model: ph = cycles since the grant edge (0 idle, 1..LAT access, LAT+1 ack cycle)
  int          ph [2] = '{0, 0};
  bit          own [2] = '{0, 0};
  bit          lg [2] = '{1, 1};
  bit          mwe [2] = '{0, 0};
  logic [31:0] maddr [2] = '{0, 0};
  logic [31:0] mdin [2] = '{0, 0};
  logic [31:0] erd_if [2] = '{0, 0};
  logic [31:0] erd_d [2] = '{0, 0};
  function automatic bit pick(input bit fi, input bit di, input bit last);
    if (fi && di) return !last;
    return di;
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++)
      if (!rst_n) begin
        ph[i] <= 0; own[i] <= 0; lg[i] <= 1; mwe[i] <= 0;
        maddr[i] <= 0; mdin[i] <= 0; erd_if[i] <= 0; erd_d[i] <= 0;
      end else if (ph[i] == 0) begin
        if (if_req[i] || d_req[i]) begin
          own[i]   <= pick(if_req[i], d_req[i], lg[i]);
          lg[i]    <= pick(if_req[i], d_req[i], lg[i]);
          mwe[i]   <= pick(if_req[i], d_req[i], lg[i]) ? d_we[i] : 1'b0;
          maddr[i] <= pick(if_req[i], d_req[i], lg[i]) ? d_addr[i] : if_addr[i];
          mdin[i]  <= pick(if_req[i], d_req[i], lg[i]) ? d_wdata[i] : 32'h0;
          ph[i]    <= 1;
        end
      end else begin
        if (ph[i] == LAT[i] && !mwe[i]) begin
          if (own[i]) erd_d[i] <= mem_dout[i];
          else erd_if[i] <= mem_dout[i];
        end
        ph[i] <= (ph[i] == LAT[i] + 1) ? 0 : ph[i] + 1;
      end
  bit acc, dn;
  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < 2; i++) begin
        acc = ph[i] >= 1 && ph[i] <= LAT[i];
        dn  = ph[i] == LAT[i] + 1;
        chk1("mem_cs", i, mem_cs[i], acc);
        chk1("mem_oe", i, mem_oe[i], acc && !mwe[i]);
        chk1("mem_we", i, mem_we[i], acc && mwe[i]);
        chk32("mem_addr", i, mem_addr[i], acc ? maddr[i] : 32'h0);
        chk32("mem_din", i, mem_din[i], acc ? mdin[i] : 32'h0);
        chk1("if_ack", i, if_ack[i], dn && !own[i]);
        chk1("d_ack", i, d_ack[i], dn && own[i]);
        chk32("if_rdata", i, if_rdata[i], erd_if[i]);
        chk32("d_rdata", i, d_rdata[i], erd_d[i]);
      end
  int          ackc, ob_n;
  logic        ob_we, ob_oe, post_cs;
  logic [31:0] ob_addr, ob_din, rd;
  // one transaction; mem_dout in cycle k (k=0 is the request cycle) is d0 ^ (step*k)
  task automatic do_txn(input int i, input bit p, input bit we, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] d0, input int step);
    @(posedge clk); #1;
    if (p) begin d_req[i] = 1; d_we[i] = we; d_addr[i] = a; d_wdata[i] = w; end
    else begin if_req[i] = 1; if_addr[i] = a; end
    mem_dout[i] = d0;
    ackc = -1; ob_n = 0;
    for (int k = 0; k < 30 && ackc < 0; k++) begin
      @(negedge clk);
      if (mem_cs[i]) begin
        ob_n++; ob_we = mem_we[i]; ob_oe = mem_oe[i]; ob_addr = mem_addr[i]; ob_din = mem_din[i];
      end
      if (p ? d_ack[i] : if_ack[i]) begin
        ackc = k;
        rd = p ? d_rdata[i] : if_rdata[i];
      end
      @(posedge clk); #1;
      mem_dout[i] = d0 ^ 32'(step * (k + 1));
    end
    if_req[i] = 0; d_req[i] = 0; d_we[i] = 0;
    @(negedge clk);
    post_cs = mem_cs[i];
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask
  // both ports keep requesting until n acks; checks order and spacing
  task automatic run_pair(input int i, input int n);
    bit who [$];
    int when [$];
    int cyc;
    bit fa, da;
    pulse_reset();
    if_req[i] = 1; if_addr[i] = $urandom;
    d_req[i] = 1; d_we[i] = 0; d_addr[i] = 32'h100;
    mem_dout[i] = $urandom;
    cyc = 0;
    while (who.size() < n && cyc < 200) begin
      @(negedge clk);
      fa = if_ack[i]; da = d_ack[i];
      chk1("ack_exclusive", i, fa & da, 1'b0);
      if (fa) begin who.push_back(0); when.push_back(cyc); end
      if (da) begin who.push_back(1); when.push_back(cyc); end
      @(posedge clk); #1;
      cyc++;
      if (fa) if_addr[i] = $urandom;
      if (da) d_addr[i] = $urandom;
      mem_dout[i] = $urandom;
    end
    if_req[i] = 0; d_req[i] = 0;
    chki("pair_count", i, who.size(), n);
    for (int k = 0; k < who.size(); k++) begin
      chki("pair_order", i, int'(who[k]), k % 2);
      if (k > 0) chki("pair_spacing", i, when[k] - when[k-1], LAT[i] + 2);
    end
    repeat (LAT[i] + 4) @(posedge clk);
  endtask
  task automatic run_random(input int ncyc);
    bit fa [2], da [2];
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin fa[i] = if_ack[i]; da[i] = d_ack[i]; end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (fa[i]) begin
          if_req[i] = (c < ncyc - 40) ? 1'($urandom_range(0, 1)) : 1'b0;
          if_addr[i] = $urandom;
        end else if (!if_req[i] && c < ncyc - 40 && $urandom_range(0, 2) == 0) begin
          if_req[i] = 1; if_addr[i] = $urandom;
        end
        if (da[i]) begin
          d_req[i] = (c < ncyc - 40) ? 1'($urandom_range(0, 1)) : 1'b0;
          d_we[i] = 1'($urandom_range(0, 1)); d_addr[i] = $urandom; d_wdata[i] = $urandom;
        end else if (!d_req[i] && c < ncyc - 40 && $urandom_range(0, 2) == 0) begin
          d_req[i] = 1; d_we[i] = 1'($urandom_range(0, 1)); d_addr[i] = $urandom; d_wdata[i] = $urandom;
        end
        mem_dout[i] = $urandom;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk1("drain_if_req", i, if_req[i], 1'b0);
      chk1("drain_d_req", i, d_req[i], 1'b0);
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 0; d_req[i] = 0; d_we[i] = 0;
      if_addr[i] = 0; d_addr[i] = 0; d_wdata[i] = 0; mem_dout[i] = 0;
    end
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1("rst_mem_cs", i, mem_cs[i], 1'b0);
      chk1("rst_if_ack", i, if_ack[i], 1'b0);
      chk1("rst_d_ack", i, d_ack[i], 1'b0);
      chk32("rst_if_rdata", i, if_rdata[i], 32'h0);
      chk32("rst_d_rdata", i, d_rdata[i], 32'h0);
      chk32("rst_mem_addr", i, mem_addr[i], 32'h0);
    end
    @(posedge clk); #1 rst_n = 1;
    do_txn(0, 0, 0, 32'h4, 32'h0, 32'h8C220010, 0);
    chki("fetch_ack_cycle", 0, ackc, 2);
    chki("fetch_access_cycles", 0, ob_n, 1);
    chk1("fetch_oe", 0, ob_oe, 1'b1);
    chk32("fetch_addr", 0, ob_addr, 32'h4);
    chk32("fetch_din", 0, ob_din, 32'h0);
    chk32("fetch_rdata", 0, rd, 32'h8C220010);
    chk1("fetch_cs_after", 0, post_cs, 1'b0);
    do_txn(0, 1, 0, 32'h40, 32'h0, 32'h1234, 0);
    chk32("preload_rdata", 0, rd, 32'h1234);
    do_txn(0, 1, 1, 32'h20, 32'hDEADBEEF, 32'hFFFF0000, 0);
    chki("write_ack_cycle", 0, ackc, 2);
    chk1("write_we", 0, ob_we, 1'b1);
    chk1("write_oe", 0, ob_oe, 1'b0);
    chk32("write_addr", 0, ob_addr, 32'h20);
    chk32("write_din", 0, ob_din, 32'hDEADBEEF);
    chk32("write_keeps_rdata", 0, rd, 32'h1234);
    do_txn(1, 1, 0, 32'h300, 32'h0, 32'h1000, 1);
    chki("lat3_ack_cycle", 1, ackc, 4);
    chki("lat3_access_cycles", 1, ob_n, 3);
    chk32("lat3_rdata", 1, rd, 32'h1003);
    @(posedge clk); #1;
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h500; mem_dout[1] = 32'hAAAA5555;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk1("midrst_mem_cs", 1, mem_cs[1], 1'b0);
    chk1("midrst_mem_oe", 1, mem_oe[1], 1'b0);
    chk32("midrst_mem_addr", 1, mem_addr[1], 32'h0);
    chk32("midrst_d_rdata", 1, d_rdata[1], 32'h0);
    chk1("midrst_d_ack", 1, d_ack[1], 1'b0);
    d_req[1] = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk1("midrst_no_ack", 1, d_ack[1] | if_ack[1], 1'b0);
    end
    do_txn(1, 0, 0, 32'h44, 32'h0, 32'h77, 0);
    chki("after_rst_ack_cycle", 1, ackc, 4);
    chk32("after_rst_rdata", 1, rd, 32'h77);
    run_pair(0, 6);
    run_pair(1, 6);
    run_random(3000);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
